immediate_gen: RTL and testbench

//  - RV32 immediate generator for the decode stage of the single-cycle/pipelined core.
//  - Decodes opcode inst[6:0], extracts the 12-bit immediate field for load, store and

---
 rtl/immediate_gen.sv | 97 +++++++++
 tb/tb_immediate_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/immediate_gen.sv
// RV32 immediate generator: opcode decode into one register stage.
// Define IMMG_IMM_ALU_EN to also decode OP-IMM and JALR as I-type.
module immediate_gen #(
  parameter int SEXT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  output logic [11:0]       immediate,
  output logic [SEXT_W-1:0] imm_sext,
  output logic              out_valid,
  output logic [1:0]        imm_fmt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef IMMG_IMM_ALU_EN
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_I    = 2'b01;
  localparam logic [1:0] FMT_S    = 2'b10;
  localparam logic [1:0] FMT_B    = 2'b11;

  logic [6:0]        opcode;
  logic              is_i;
  logic              is_s;
  logic              is_b;
  logic [11:0]       imm_d;
  logic [SEXT_W-1:0] sext_d;
  logic [1:0]        fmt_d;

  assign opcode = instruction[6:0];

`ifdef IMMG_IMM_ALU_EN
  assign is_i = (opcode == OP_LOAD) ||
                (opcode == OP_IMM)  ||
                (opcode == OP_JALR);
`else
  assign is_i = (opcode == OP_LOAD);
`endif
  assign is_s = (opcode == OP_STORE);
  assign is_b = (opcode == OP_BRANCH);

  // Extract the immediate field and its byte-offset sign extension.
  always_comb begin
    imm_d  = 12'h000;
    sext_d = '0;
    fmt_d  = FMT_NONE;
    unique case (1'b1)
      is_i: begin
        imm_d  = instruction[31:20];
        sext_d = SEXT_W'($signed(imm_d));
        fmt_d  = FMT_I;
      end
      is_s: begin
        imm_d  = {instruction[31:25],
                  instruction[11:7]};
        sext_d = SEXT_W'($signed(imm_d));
        fmt_d  = FMT_S;
      end
      is_b: begin
        imm_d  = {instruction[31],
                  instruction[7],
                  instruction[30:25],
                  instruction[11:8]};
        sext_d = SEXT_W'($signed({imm_d, 1'b0}));
        fmt_d  = FMT_B;
      end
      default: begin
        imm_d  = 12'h000;
        sext_d = '0;
        fmt_d  = FMT_NONE;
      end
    endcase
  end

  // Register the decoded result every cycle; in_valid only rides along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immediate <= 12'h000;
      imm_sext  <= '0;
      out_valid <= 1'b0;
      imm_fmt   <= FMT_NONE;
    end else begin
      immediate <= imm_d;
      imm_sext  <= sext_d;
      out_valid <= in_valid;
      imm_fmt   <= fmt_d;
    end
  end

endmodule

// File: tb/tb_immediate_gen.sv
// Randomized bench for immediate_gen with a behavioural reference model.
// Honors IMMG_IMM_ALU_EN the same way the design does.
module tb_immediate_gen;

  localparam int SEXT_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [31:0]       instruction = 32'h0;
  logic [11:0]       immediate;
  logic [SEXT_W-1:0] imm_sext;
  logic              out_valid;
  logic [1:0]        imm_fmt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [11:0]       exp_imm = '0;
  logic [SEXT_W-1:0] exp_sext = '0;
  logic              exp_vld = 1'b0;
  logic [1:0]        exp_fmt = '0;

  immediate_gen #(.SEXT_W(SEXT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .instruction(instruction),
    .immediate(immediate),
    .imm_sext(imm_sext),
    .out_valid(out_valid),
    .imm_fmt(imm_fmt)
  );

  always #5 clk = ~clk;

  // Reference: field extraction by shifts/masks, sign extension by arithmetic.
  function automatic void model(
    input  logic [31:0]       ins,
    output logic [11:0]       imm,
    output logic [SEXT_W-1:0] sx,
    output logic [1:0]        fmt
  );
    longint u;
    longint op;
    longint f;
    longint v;
    bit     alu;
    u   = longint'({32'h0, ins});
    op  = u & 127;
    f   = 0;
    v   = 0;
    fmt = 2'd0;
`ifdef IMMG_IMM_ALU_EN
    alu = (op == 19) || (op == 103);
`else
    alu = 1'b0;
`endif
    if (op == 3 || alu) begin
      f   = (u >> 20) & 4095;
      v   = (f >= 2048) ? f - 4096 : f;
      fmt = 2'd1;
    end else if (op == 35) begin
      f   = ((u >> 25) << 5) | ((u >> 7) & 31);
      v   = (f >= 2048) ? f - 4096 : f;
      fmt = 2'd2;
    end else if (op == 99) begin
      f   = ((u >> 31) << 11) | (((u >> 7) & 1) << 10)
          | (((u >> 25) & 63) << 4) | ((u >> 8) & 15);
      v   = (f >= 2048) ? 2 * f - 8192 : 2 * f;
      fmt = 2'd3;
    end
    imm = 12'(f);
    sx  = SEXT_W'(v);
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model register: same latency and async clear as the block under test.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_imm  = '0;
      exp_sext = '0;
      exp_vld  = 1'b0;
      exp_fmt  = '0;
    end else begin
      model(instruction, exp_imm, exp_sext, exp_fmt);
      exp_vld = in_valid;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imm", 64'(immediate), 64'(exp_imm));
      check("sext", 64'(imm_sext), 64'(exp_sext));
      check("vld", 64'(out_valid), 64'(exp_vld));
      check("fmt", 64'(imm_fmt), 64'(exp_fmt));
    end
  end

  task automatic pin(input string name,
                     input logic [31:0] ins,
                     input logic [11:0] e_imm,
                     input logic [SEXT_W-1:0] e_sx,
                     input logic [1:0] e_fmt);
    logic [11:0]       m_imm;
    logic [SEXT_W-1:0] m_sx;
    logic [1:0]        m_fmt;
    model(ins, m_imm, m_sx, m_fmt);
    check({name, "_model_imm"}, 64'(m_imm), 64'(e_imm));
    check({name, "_model_sext"}, 64'(m_sx), 64'(e_sx));
    check({name, "_model_fmt"}, 64'(m_fmt), 64'(e_fmt));
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    instruction = ins;
    @(posedge clk);
    #1;
    check({name, "_imm"}, 64'(immediate), 64'(e_imm));
    check({name, "_sext"}, 64'(imm_sext), 64'(e_sx));
    check({name, "_fmt"}, 64'(imm_fmt), 64'(e_fmt));
    check({name, "_vld"}, 64'(out_valid), 64'(1'b1));
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = int'($urandom_range(0, 7));
    case (k)
      0: r[6:0] = 7'b0000011;
      1: r[6:0] = 7'b0100011;
      2: r[6:0] = 7'b1100011;
      3: r[6:0] = 7'b0010011;
      4: r[6:0] = 7'b1100111;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_imm", 64'(immediate), 64'h0);
    check("rst_sext", 64'(imm_sext), 64'h0);
    check("rst_vld", 64'(out_valid), 64'h0);
    check("rst_fmt", 64'(imm_fmt), 64'h0);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    pin("dflt", 32'hFFFFFF80, 12'h000, 32'h0, 2'b00);
    pin("beq", 32'h0FFFFF63, 12'h07F, 32'h000000FE, 2'b11);
    pin("bneg", 32'h80000063, 12'h800, 32'hFFFFF000, 2'b11);
    pin("lw", 32'h557FFF83, 12'h557, 32'h00000557, 2'b01);
    pin("lw555", 32'h55500003, 12'h555, 32'h00000555, 2'b01);
    pin("lwneg", 32'hFFF00003, 12'hFFF, 32'hFFFFFFFF, 2'b01);
    pin("sw", 32'h55FFFAA3, 12'h555, 32'h00000555, 2'b10);
    pin("swneg", 32'hFE000FA3, 12'hFFF, 32'hFFFFFFFF, 2'b10);
`ifdef IMMG_IMM_ALU_EN
    pin("opimm", 32'h7FF00013, 12'h7FF, 32'h000007FF, 2'b01);
    pin("jalr", 32'h800000E7, 12'h800, 32'hFFFFF800, 2'b01);
`else
    pin("opimm", 32'h7FF00013, 12'h000, 32'h0, 2'b00);
    pin("jalr", 32'h800000E7, 12'h000, 32'h0, 2'b00);
`endif

    // Async reset between edges with LW in flight.
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    instruction = 32'h557FFF83;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_imm", 64'(immediate), 64'h0);
    check("arst_sext", 64'(imm_sext), 64'h0);
    check("arst_vld", 64'(out_valid), 64'h0);
    check("arst_fmt", 64'(imm_fmt), 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("hold_imm", 64'(immediate), 64'h0);
    check("hold_vld", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;
    check("rel_imm", 64'(immediate), 64'h557);
    check("rel_vld", 64'(out_valid), 64'h1);

    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      in_valid    = 1'($urandom_range(0, 1));
      instruction = rand_ins();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
